// File: rtl/rst_req_tx_if.sv
// Handshake-side signal bundle of the reset-request transmitter.
// The master side raises requests and plays the acknowledging partner.
// The slave side is the transmitter itself.
`timescale 1ns/1ps
interface rst_req_tx_if;
  logic       rst_req;
  logic       ack_async;
  logic       req_out;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [7:0] drop_cnt;

  modport master (
    output rst_req, ack_async,
    input  req_out, busy, done, timeout_err, drop_cnt
  );

  modport slave (
    input  rst_req, ack_async,
    output req_out, busy, done, timeout_err, drop_cnt
  );
endinterface

// File: rtl/rst_req_tx.sv
// Reset-request transmitter (clk50 domain).
// It turns single-cycle reset requests into a four-phase req/ack level handshake
// toward the ipb_clk domain. Requests that arrive mid-handshake are coalesced
// into one pending request, and the extra requests are counted as drops.
// A phase that waits longer than TIMEOUT cycles is aborted and flagged.
`timescale 1ns/1ps
module rst_req_tx #(
  parameter int TIMEOUT = 1000  // legal range 2..65535
) (
  input logic         clk50,
  input logic         rst_clk50,
  rst_req_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        ack_s1;
  logic        ack_sync;
  logic        pending;
  logic [15:0] cnt;
  logic        start;

  // A handshake starts only from IDLE, and only once the previous ack has dropped.
  assign start = (state == IDLE) && !ack_sync && (bus.rst_req || pending);

  // Two-flop synchronizer that brings the foreign ack into clk50.
  always_ff @(posedge clk50 or posedge rst_clk50) begin
    if (rst_clk50) begin
      ack_s1   <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking, so ack_sync takes last cycle's ack_s1 and both stages really exist.
      ack_s1   <= bus.ack_async;
      ack_sync <= ack_s1;
    end
  end

  // Request coalescing, drop counting and the handshake FSM with registered outputs.
  always_ff @(posedge clk50 or posedge rst_clk50) begin
    if (rst_clk50) begin
      state           <= IDLE;
      pending         <= 1'b0;
      cnt             <= '0;
      bus.req_out     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.drop_cnt    <= '0;
    end else begin
      bus.done <= 1'b0;

      // A start consumes the pending request. A simultaneous new request re-arms pending.
      if (start) begin
        pending <= pending && bus.rst_req;
      end else if (bus.rst_req) begin
        pending <= 1'b1;
        if (pending && bus.drop_cnt != 8'hFF) begin
          bus.drop_cnt <= bus.drop_cnt + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ASSERT;
            bus.req_out <= 1'b1;
            bus.busy    <= 1'b1;
            cnt         <= '0;
          end
        end

        ASSERT: begin
          if (ack_sync) begin
            state       <= RELEASE;
            bus.req_out <= 1'b0;
            cnt         <= '0;
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            bus.req_out     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RELEASE: begin
          if (!ack_sync) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.timeout_err <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state       <= IDLE;
          bus.req_out <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_req_tx.sv
// Self-checking bench for rst_req_tx.
// It runs a vector table, randomized traffic against a timing model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_rst_req_tx;

  localparam int TIMEOUT = 10;

  logic clk50 = 1'b0;
  logic rst_clk50;

  rst_req_tx_if bus ();

  rst_req_tx #(.TIMEOUT(TIMEOUT)) dut (
    .clk50     (clk50),
    .rst_clk50 (rst_clk50),
    .bus       (bus)
  );

  always #10 clk50 = ~clk50;

  int          tests = 0;
  int          fails = 0;
  int          dones = 0;
  logic        partner_en = 1'b0;
  int          d = 1;
  logic        man_ack = 1'b0;
  logic [31:0] hist = '0;

  typedef struct packed {
    logic req;
    logic ack;
    logic req_out;
    logic busy;
    logic done;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle. Inputs change on the falling edge, and outputs are sampled 1 ns after the rising edge.
  // The partner drives ack to the value req_out had d-1 falling edges ago.
  task automatic tick(input logic req);
    @(negedge clk50);
    hist          = {hist[30:0], bus.req_out};
    bus.ack_async = partner_en ? hist[d-1] : man_ack;
    bus.rst_req   = req;
    @(posedge clk50);
    #1;
    if (bus.done) dones++;
  endtask

  task automatic do_reset();
    @(negedge clk50);
    rst_clk50     = 1'b1;
    bus.rst_req   = 1'b0;
    bus.ack_async = 1'b0;
    man_ack       = 1'b0;
    hist          = '0;
    @(negedge clk50);
    rst_clk50 = 1'b0;
    dones     = 0;
  endtask

  // Timing model: a handshake started at edge S with partner delay dd gives the following, k edges after S:
  // req_out for k in 0..dd+1, busy for 0..2dd+3, done at 2dd+4.
  // The next start is possible at S+2dd+5.
  task automatic run_random(input int dd, input int n);
    int   start;
    int   drops;
    int   k;
    logic pend;
    logic r;
    logic e_req;
    logic e_busy;
    logic e_done;
    start = -1;
    drops = 0;
    pend  = 1'b0;
    do_reset();
    partner_en = 1'b1;
    d          = dd;
    for (int e = 0; e < n; e++) begin
      r = ($urandom_range(0, 4) == 0);
      tick(r);
      if ((start < 0 || e >= start + 2*dd + 5) && (pend || r)) begin
        start = e;
        pend  = pend && r;
      end else if (r) begin
        if (pend) drops = (drops < 255) ? drops + 1 : 255;
        pend = 1'b1;
      end
      k      = (start < 0) ? -1 : e - start;
      e_req  = (k >= 0) && (k <= dd + 1);
      e_busy = (k >= 0) && (k <= 2*dd + 3);
      e_done = (k == 2*dd + 4);
      check($sformatf("rand_d%0d_e%0d", dd, e),
            {bus.req_out, bus.busy, bus.done, bus.timeout_err, bus.drop_cnt},
            {e_req, e_busy, e_done, 1'b0, 8'(drops)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int fall_i;
    int err_i;
    int cyc;
    int seen;

    // ---------------- reset state ----------------
    rst_clk50     = 1'b1;
    bus.rst_req   = 1'b0;
    bus.ack_async = 1'b0;
    @(negedge clk50);
    @(negedge clk50);
    check("rst_req_out", bus.req_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
    rst_clk50 = 1'b0;

    // ---- vector table: minimal handshake, request while busy, back-to-back ----
    //              req   ack   req_out busy  done
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    partner_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      man_ack = vecs[i].ack;
      tick(vecs[i].req);
      check($sformatf("vec%0d", i),
            {bus.req_out, bus.busy, bus.done, bus.timeout_err, bus.drop_cnt},
            {vecs[i].req_out, vecs[i].busy, vecs[i].done, 1'b0, 8'd0});
    end

    // ---------------- randomized traffic, partner delays 1..4 ----------------
    for (int dd = 1; dd <= 4; dd++) run_random(dd, 250);

    // ---------------- coalescing and drop saturation ----------------
    do_reset();
    partner_en = 1'b1;
    d          = 1;
    for (int i = 0; i < 4; i++) tick(1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0);
    check("coalesce_dones", dones, 2);
    check("coalesce_drops", bus.drop_cnt, 2);
    check("coalesce_idle", bus.busy, 0);
    for (int i = 0; i < 300; i++) tick(1'b1);
    check("drop_saturate", bus.drop_cnt, 255);
    for (int i = 0; i < 20; i++) tick(1'b0);
    check("drop_sticky", bus.drop_cnt, 255);

    // ---------------- ASSERT timeout ----------------
    do_reset();
    partner_en = 1'b0;
    man_ack    = 1'b0;
    hi         = 0;
    fall_i     = -1;
    err_i      = -1;
    tick(1'b1);
    if (bus.req_out) hi++;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0);
      if (bus.req_out) hi++;
      if (!bus.req_out && fall_i < 0) fall_i = i;
      if (bus.timeout_err && err_i < 0) err_i = i;
    end
    check("to_req_cycles", hi, TIMEOUT);
    check("to_err_same_edge", err_i, fall_i);
    check("to_err", bus.timeout_err, 1);
    check("to_no_done", dones, 0);
    check("to_idle", bus.busy, 0);
    partner_en = 1'b1;
    d          = 1;
    tick(1'b1);
    for (int i = 0; i < 12; i++) tick(1'b0);
    check("to_recover_done", dones, 1);
    check("to_recover_clear", bus.timeout_err, 0);

    // ---------------- stuck ack after a RELEASE abort ----------------
    do_reset();
    partner_en = 1'b0;
    man_ack    = 1'b0;
    tick(1'b1);
    man_ack = 1'b1;
    cyc     = 0;
    tick(1'b0);
    while (bus.busy && cyc < 60) begin
      tick(1'b0);
      cyc++;
    end
    check("stuck_abort_in_bound", bus.busy, 0);
    check("stuck_err", bus.timeout_err, 1);
    check("stuck_no_done", dones, 0);
    tick(1'b1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      if (bus.req_out || bus.busy) seen++;
    end
    check("stuck_held_idle", seen, 0);
    man_ack = 1'b0;
    tick(1'b0);
    tick(1'b0);
    check("stuck_k1_req", bus.req_out, 0);
    tick(1'b0);
    check("stuck_k2_req", bus.req_out, 1);
    check("stuck_no_drop", bus.drop_cnt, 0);

    // ---------------- request in the IDLE cycle that consumes pending ----------------
    do_reset();
    partner_en = 1'b1;
    d          = 1;
    tick(1'b1);
    tick(1'b1);
    for (int i = 2; i <= 6; i++) tick(1'b0);
    check("simul_done1", bus.done, 1);
    tick(1'b1);
    check("simul_start2", bus.req_out, 1);
    for (int i = 8; i <= 13; i++) tick(1'b0);
    check("simul_done2", bus.done, 1);
    tick(1'b0);
    check("simul_start3", bus.req_out, 1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    check("simul_dones", dones, 3);
    check("simul_no_drop", bus.drop_cnt, 0);

    // ---------------- asynchronous reset mid-ASSERT with pending ----------------
    do_reset();
    partner_en = 1'b0;
    man_ack    = 1'b0;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    check("mid_pre_req", bus.req_out, 1);
    #3;
    rst_clk50 = 1'b1;
    #1;
    check("mid_req_out", bus.req_out, 0);
    check("mid_outs",
          {bus.busy, bus.done, bus.timeout_err, bus.drop_cnt},
          {1'b0, 1'b0, 1'b0, 8'd0});
    @(negedge clk50);
    rst_clk50 = 1'b0;
    seen      = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      if (bus.req_out || bus.busy) seen++;
    end
    check("mid_no_handshake", seen, 0);
    tick(1'b1);
    check("mid_new_req", bus.req_out, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rst_req_tx.md
# rst_req_tx

Reset-request transmitter in the clk50 domain: turns single-cycle reset requests into a four-phase level handshake (req/ack) toward the ipb_clk domain, where the receiving logic turns an accepted request into its own reset. It is the originating end of the slow-to-fast reset path. It synchronizes the returning ack, coalesces requests that arrive while a handshake is in flight, counts overflowed requests and flags handshakes that time out.

## Interface
- TIMEOUT, 1000: maximum clk50 cycles spent waiting in either handshake phase before abort; legal range 2..65535.
- clk50  in  1  sole clock; all logic on rising edge.
- rst_clk50  in  1  asynchronous, active-high reset.
- rst_req  in  1  single-cycle reset request, synchronous to clk50.
- ack_async  in  1  acknowledge from the ipb_clk domain; not synchronous to clk50.
- req_out  out  1  request level to the ipb_clk domain; registered.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a handshake completes.
- timeout_err  out  1  sticky abort flag.
- drop_cnt  out  8  saturating count of requests lost to coalescing.

## Operation
- Ack synchronizer: two flops, ack_s1 then ack_sync, both reset to 0. The FSM uses only ack_sync.
- Pending flag:
  - Set by rst_req when the request is not consumed in the same cycle.
  - Cleared when the FSM leaves IDLE for ASSERT.
  - If rst_req arrives while pending is already 1, pending stays 1 and drop_cnt increments, saturating at 255.
- State IDLE, req_out=0:
  - If (rst_req or pending) and ack_sync=0: go to ASSERT, clear pending, zero the timeout counter.
  - If ack_sync=1 (previous ack still high after an abort): stay in IDLE; rst_req sets pending.
- State ASSERT, req_out=1:
  - ack_sync=1: go to RELEASE, counter zeroed.
  - Counter = TIMEOUT-1 with ack_sync still 0: abort.
  - Otherwise the counter increments.
- State RELEASE, req_out=0:
  - ack_sync=0: go to IDLE, pulse done, clear timeout_err.
  - Counter = TIMEOUT-1 with ack_sync still 1: abort.
- Abort: next state IDLE, timeout_err set to 1, pending unchanged, done not pulsed.
- Timeout counter: 16 bits, never wraps, because leaving the state at TIMEOUT-1 bounds it.
- rst_req while busy goes into pending; it is never dropped unless pending is already set.
- rst_req in the same cycle that IDLE consumes pending: the FSM goes to ASSERT, and pending is set again by the new rst_req (no drop).
- drop_cnt is cleared only by rst_clk50.

## Timing
- Reset values: req_out=0, busy=0, done=0, timeout_err=0, drop_cnt=0, state IDLE, pending=0, synchronizer flops 0.
- Reset is asynchronous. Assertion mid-handshake forces req_out low immediately and discards pending.
- Request latency: rst_req sampled high at edge N (IDLE, ack_sync=0) gives req_out=1 and busy=1 after edge N.
- Ack latency: ack_async rising before edge M is seen in ack_sync after edge M+1. req_out falls after edge M+2.
- Completion: ack_async falling before edge K gives done=1 for the cycle following edge K+2; busy falls at that same edge.
- Minimum handshake with an instantly responding partner: 6 cycles from req_out rising to done.
- Back-to-back: with pending set, the next req_out rises at the edge after done's cycle (IDLE lasts one cycle).
- Abort timing: ASSERT is left after exactly TIMEOUT cycles in the state; timeout_err rises at that same edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic handshake: ack_async follows req_out with 3-cycle latency, single rst_req -> req_out high 1 cycle after rst_req, exactly one done pulse, busy low afterwards, drop_cnt=0.
- Coalescing: 4 rst_req pulses during one handshake -> exactly two handshakes, drop_cnt=2; a further 300 extra requests saturate drop_cnt at 255.
- ASSERT timeout: TIMEOUT=10, ack_async held 0 -> req_out high for exactly 10 cycles, timeout_err=1, no done; next successful handshake clears timeout_err.
- Stuck ack: ack_async held 1 after an abort, then rst_req -> pending held and FSM stays in IDLE; ack_async drops -> ASSERT starts 3 cycles later.
- Simultaneous events: rst_req in the IDLE cycle that consumes pending -> handshake starts, pending set again, drop_cnt unchanged.
- Reset mid-operation: rst_clk50 pulsed while in ASSERT with pending=1 -> req_out 0 immediately, all outputs at reset values, no handshake after release until a new rst_req.
